// File: rtl/mux_pkg.sv
// Shared constants and types for the 4-channel byte arbiter and its 4:1 mux.
package mux_pkg;

  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;
  localparam int DATA_W   = 8;

  // Occupancy of the single-entry output register.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage : mux_pkg

// File: rtl/mux4_8bit.sv
// Purely combinational 4:1 byte multiplexer; the arbiter grant drives its select.
module mux4_8bit
  import mux_pkg::*;
(
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [DATA_W-1:0] i_d0,
  input  logic [DATA_W-1:0] i_d1,
  input  logic [DATA_W-1:0] i_d2,
  input  logic [DATA_W-1:0] i_d3,
  output logic [DATA_W-1:0] o_y
);

  // Route the selected channel byte to the output.
  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule : mux4_8bit

// File: rtl/rr_arb4_8bit.sv
// Four-channel round-robin byte arbiter feeding a registered single-entry
// output stage with a valid/ready handshake.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (channel 0 highest,
// no rotation pointer). Default build is round-robin.
module rr_arb4_8bit
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in_valid,
  input  logic [WIDTH-1:0]    in_data0,
  input  logic [WIDTH-1:0]    in_data1,
  input  logic [WIDTH-1:0]    in_data2,
  input  logic [WIDTH-1:0]    in_data3,
  output logic [CHANNELS-1:0] in_ready,
  output logic [SEL_W-1:0]    sel,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic [SEL_W-1:0]    out_chan,
  input  logic                out_ready
);

  // First valid channel at or after p, wrapping modulo four. Scanning from the
  // farthest offset down lets the nearest valid channel overwrite the result.
  function automatic logic [SEL_W-1:0] grant_idx(input logic [CHANNELS-1:0] v,
                                                 input logic [SEL_W-1:0]    p);
    logic [SEL_W-1:0] g;
    logic [SEL_W-1:0] idx;
    g = p;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = p + SEL_W'(k);
      if (v[idx]) g = idx;
    end
    return g;
  endfunction

  state_t            r_state;
  logic [WIDTH-1:0]  r_data;
  logic [SEL_W-1:0]  r_chan;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  w_ptr;
  logic [SEL_W-1:0]  w_grant;
  logic [SEL_W-1:0]  w_sel;
  logic [DATA_W-1:0] w_mux_y;
  logic              w_any;
  logic              w_slot_free;
  logic              w_in_xfer;
  logic              w_out_xfer;

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at channel 0.
  assign w_ptr = '0;
`else
  logic [SEL_W-1:0] r_ptr;
  assign w_ptr = r_ptr;
`endif

  assign w_any       = |in_valid;
  assign w_grant     = grant_idx(in_valid, w_ptr);
  assign w_slot_free = (r_state == EMPTY) | out_ready;
  // Nothing is accepted while reset is held, so a byte cannot slip past it.
  assign w_in_xfer   = w_any & w_slot_free & ~rst;
  assign w_out_xfer  = (r_state == FULL) & out_ready;
  // With no requester the select parks on its previous value.
  assign w_sel       = rst ? '0 : (w_any ? w_grant : r_sel);

  // One-hot accept for the granted channel only.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
    assign in_ready[gi] = w_in_xfer & (w_grant == SEL_W'(gi));
  end

  mux4_8bit u_mux (
    .i_sel (w_sel),
    .i_d0  (in_data0),
    .i_d1  (in_data1),
    .i_d2  (in_data2),
    .i_d3  (in_data3),
    .o_y   (w_mux_y)
  );

  // Output register, occupancy state, parked select and rotation pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_chan  <= '0;
      r_sel   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      r_ptr   <= '0;
`endif
    end else begin
      r_sel <= w_sel;
      if (w_in_xfer) begin
        // Load (possibly while the old byte leaves on the same edge).
        r_state <= FULL;
        r_data  <= w_mux_y;
        r_chan  <= w_grant;
`ifndef ARB_FIXED_PRIO_EN
        r_ptr   <= w_grant + 1'b1;
`endif
      end else if (w_out_xfer) begin
        r_state <= EMPTY;
      end
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign sel       = w_sel;

endmodule : rr_arb4_8bit

// File: tb/tb_rr_arb4_8bit.sv
// Self-checking bench for rr_arb4_8bit: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of the arbiter.
module tb_rr_arb4_8bit;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_valid;
  logic [7:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_ready;
  logic [1:0] sel;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_chan;
  logic       out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  bit         m_full;
  logic [7:0] m_data;
  logic [1:0] m_chan;
  int         m_ptr;
  logic [1:0] m_sel;
  logic [3:0] e_ready;
  logic [1:0] e_sel;

  rr_arb4_8bit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] data_of(input int c);
    case (c)
      0:       return in_data0;
      1:       return in_data1;
      2:       return in_data2;
      default: return in_data3;
    endcase
  endfunction

  // Expected combinational outputs from the model state and current inputs.
  function void model_comb();
    int g;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (g < 0 && in_valid[c]) g = c;
    end
    e_ready = 4'b0000;
    if (rst) e_sel = 2'd0;
    else if (g >= 0) e_sel = 2'(g);
    else e_sel = m_sel;
    if (g >= 0 && !rst && (!m_full || out_ready)) e_ready[g] = 1'b1;
  endfunction

  // Advance one clock and update the model with the inputs seen at the edge.
  task automatic advance();
    int g;
    model_comb();
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_data = 8'h00; m_chan = 2'd0; m_ptr = 0; m_sel = 2'd0;
    end else begin
      m_sel = e_sel;
      g = -1;
      for (int k = 0; k < 4; k++) if (e_ready[k]) g = k;
      if (g >= 0) begin
        m_full = 1; m_data = data_of(g); m_chan = 2'(g);
        if (!FIXED) m_ptr = (g + 1) % 4;
      end else if (m_full && out_ready) begin
        m_full = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 4'b0000; out_ready = 0;
    in_data0 = 8'h00; in_data1 = 8'h00; in_data2 = 8'h00; in_data3 = 8'h00;
    advance(); advance();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", out_data); end
    n_cmp++; if (out_chan !== 2'd0) begin n_bad++; $display("FAIL reset_chan got %0d want 0", out_chan); end
    n_cmp++; if (sel !== 2'd0) begin n_bad++; $display("FAIL reset_sel got %0d want 0", sel); end
    n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got %b want 0000", in_ready); end
    $display("reset: out_valid=%b out_data=%h sel=%0d", out_valid, out_data, sel);
  endtask

  task automatic test_single();
    rst = 0; in_valid = 4'b0100; in_data2 = 8'hA5; out_ready = 1;
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready got %b want 0100", in_ready); end
    n_cmp++; if (sel !== 2'd2) begin n_bad++; $display("FAIL single_sel got %0d want 2", sel); end
    advance();
    in_valid = 4'b0000;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'hA5) begin n_bad++; $display("FAIL single_data got %h want a5", out_data); end
    n_cmp++; if (out_chan !== 2'd2) begin n_bad++; $display("FAIL single_chan got %0d want 2", out_chan); end
    $display("single: out_data=%h out_chan=%0d", out_data, out_chan);
    advance();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain got %b want 0", out_valid); end
  endtask

  // Runs right after test_single, so the pointer sits at 3.
  task automatic test_sparse();
    in_valid = 4'b0110; in_data1 = 8'h21; in_data2 = 8'h22; out_ready = 1;
    #1;
    n_cmp++; if (sel !== 2'd1) begin n_bad++; $display("FAIL sparse_sel1 got %0d want 1", sel); end
    n_cmp++; if (in_ready !== 4'b0010) begin n_bad++; $display("FAIL sparse_ready1 got %b want 0010", in_ready); end
    advance();
    n_cmp++; if (out_chan !== 2'd1) begin n_bad++; $display("FAIL sparse_chan1 got %0d want 1", out_chan); end
    in_valid = 4'b0100;
    #1;
    n_cmp++; if (sel !== 2'd2) begin n_bad++; $display("FAIL sparse_sel2 got %0d want 2", sel); end
    advance();
    n_cmp++; if (out_chan !== 2'd2 || out_data !== 8'h22) begin n_bad++; $display("FAIL sparse_chan2 got %0d/%h want 2/22", out_chan, out_data); end
    $display("sparse: second grant chan=%0d data=%h", out_chan, out_data);
    in_valid = 4'b0000;
    advance();
  endtask

  task automatic test_all_channels();
    rst = 1; advance(); rst = 0;
    in_valid = 4'b1111; out_ready = 1;
    in_data0 = 8'h10; in_data1 = 8'h11; in_data2 = 8'h12; in_data3 = 8'h13;
    for (int i = 0; i < 5; i++) begin
      advance();
      n_cmp++;
      if (out_valid !== 1'b1 || out_chan !== 2'(i % 4) || out_data !== 8'(8'h10 + i % 4)) begin
        n_bad++;
        $display("FAIL all_rotate[%0d] got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                 i, out_valid, out_chan, out_data, i % 4, 8'h10 + i % 4);
      end
      $display("all: cycle %0d out_chan=%0d out_data=%h", i, out_chan, out_data);
    end
    in_valid = 4'b0000; advance();
  endtask

  task automatic test_backpressure();
    rst = 1; advance(); rst = 0;
    in_valid = 4'b0010; in_data1 = 8'h11; out_ready = 1;
    advance();
    in_valid = 4'b1111; in_data0 = 8'h10; in_data2 = 8'h12; in_data3 = 8'h13; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready[%0d] got %b want 0000", i, in_ready); end
      n_cmp++; if (sel !== 2'd2) begin n_bad++; $display("FAIL bp_sel[%0d] got %0d want 2", i, sel); end
      advance();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin n_bad++; $display("FAIL bp_hold[%0d] got v=%b d=%h want v=1 d=11", i, out_valid, out_data); end
      $display("backpressure: stall %0d out_data=%h", i, out_data);
    end
    out_ready = 1;
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_release_ready got %b want 0100", in_ready); end
    advance();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h12 || out_chan !== 2'd2) begin n_bad++; $display("FAIL bp_reload got v=%b d=%h ch=%0d want v=1 d=12 ch=2", out_valid, out_data, out_chan); end
    $display("backpressure: reload out_data=%h out_chan=%0d", out_data, out_chan);
  endtask

  task automatic test_reset_full();
    in_valid = 4'b0001; in_data0 = 8'h5A; out_ready = 1; rst = 0;
    advance();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rf_prefill got %b want 1", out_valid); end
    in_valid = 4'b1000; in_data3 = 8'h33; out_ready = 0; rst = 1;
    #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL rf_ready_in_reset got %b want 0000", in_ready); end
    advance();
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || sel !== 2'd0) begin n_bad++; $display("FAIL rf_cleared got v=%b d=%h sel=%0d want 0/00/0", out_valid, out_data, sel); end
    rst = 0;
    #1;
    n_cmp++; if (in_ready !== 4'b1000 || sel !== 2'd3) begin n_bad++; $display("FAIL rf_pending got ready=%b sel=%0d want 1000/3", in_ready, sel); end
    advance();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h33 || out_chan !== 2'd3) begin n_bad++; $display("FAIL rf_accept got v=%b d=%h ch=%0d want 1/33/3", out_valid, out_data, out_chan); end
    $display("reset_full: accepted after reset data=%h chan=%0d", out_data, out_chan);
  endtask

  task automatic test_fixed_prio();
    rst = 1; advance(); rst = 0;
    in_valid = 4'b1001; in_data0 = 8'hC0; in_data3 = 8'hC3; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL fixed_ready[%0d] got %b want 0001", i, in_ready); end
      advance();
      n_cmp++; if (out_chan !== 2'd0 || out_data !== 8'hC0) begin n_bad++; $display("FAIL fixed_chan[%0d] got %0d/%h want 0/c0", i, out_chan, out_data); end
      $display("fixed: cycle %0d out_chan=%0d", i, out_chan);
    end
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = n_bad;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data0  = 8'($urandom); in_data1 = 8'($urandom);
      in_data2  = 8'($urandom); in_data3 = 8'($urandom);
      #1;
      model_comb();
      n_cmp++; if (in_ready !== e_ready) begin n_bad++; $display("FAIL rand_ready[%0d] got %b want %b", i, in_ready, e_ready); end
      n_cmp++; if (sel !== e_sel) begin n_bad++; $display("FAIL rand_sel[%0d] got %0d want %0d", i, sel, e_sel); end
      advance();
      n_cmp++;
      if (out_valid !== m_full || (m_full && (out_data !== m_data || out_chan !== m_chan))) begin
        n_bad++;
        $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                 i, out_valid, out_data, out_chan, m_full, m_data, m_chan);
      end
      $display("random %0d: rst=%b valid=%b ready=%b out_ready=%b -> out v=%b d=%h ch=%0d",
               i, rst, in_valid, in_ready, out_ready, out_valid, out_data, out_chan);
    end
    $display("random: %0d new mismatches", n_bad - errs_before);
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_sparse();
    test_all_channels();
    test_backpressure();
`endif
    test_reset_full();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_rr_arb4_8bit

// File: doc/rr_arb4_8bit.md
# rr_arb4_8bit

Four-channel, 8-bit round-robin arbiter that sits directly upstream of the 4:1 byte multiplexer. It takes four valid/ready byte streams, picks one per cycle, drives the mux select, and registers the selected byte into a single-entry output stage with a valid/ready handshake. It turns the purely combinational select path into a flow-controlled merge point for the combinational datapath.

## Interface
- `WIDTH`, default 8: data width per channel (mux instance is 8-bit; values other than 8 are unsupported).
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 4: per-channel request; bit i belongs to channel i.
- `in_data0`..`in_data3`, input, WIDTH each: channel payloads.
- `in_ready`, output, 4: per-channel accept. At most one bit is high per cycle.
- `sel`, output, 2: current grant index, the same value that drives the internal mux select.
- `out_valid`, output, 1: output register holds a byte.
- `out_data`, output, WIDTH: registered byte.
- `out_chan`, output, 2: source channel of `out_data`.
- `out_ready`, input, 1: downstream accept.

## Operation
- Output register has two states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- `slot_free = !out_valid | out_ready`.
- Grant: first channel with `in_valid` high, searching circularly from pointer `ptr` (ptr, ptr+1, … mod 4).
  - `sel` = granted index.
  - If no channel is valid, `sel` holds its last value.
- `in_ready[g] = in_valid[g] & slot_free` for the granted g. All other `in_ready` bits are 0.
- Input transfer: `in_valid[g] & in_ready[g]`. On the next edge:
  - `out_data` ← mux output.
  - `out_chan` ← g.
  - `out_valid` ← 1.
  - `ptr` ← (g+1) mod 4.
- Output transfer: `out_valid & out_ready`.
  - With no simultaneous input transfer: `out_valid` ← 0.
  - Simultaneous input and output transfer in the same cycle is legal. The register reloads and stays FULL, so throughput is one byte per cycle.
- FULL and `!out_ready`:
  - `out_data` and `out_chan` are held stable.
  - All `in_ready` bits are 0.
  - `ptr` does not advance.
- `ptr` advances only on an input transfer. Requests alone never move it.
- Upstream rule: a channel must hold `in_valid` and its data until it is accepted. Dropping `in_valid` before acceptance is tolerated; grant moves to the next valid channel.
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0, `ptr`=0, `sel`=0.
- Reset mid-operation: a byte held in the output register is discarded. No `in_ready` is asserted in the reset cycle.

## Timing
- Input-to-output latency: 1 cycle. A byte accepted at edge k is visible on `out_data` after edge k.
- `in_ready` and `sel` are combinational from `in_valid`, `ptr`, `out_valid` and `out_ready`.
- No combinational path from `in_data*` to any output other than through the register.
- Full throughput: 1 byte/cycle while `out_ready`=1.
- Fairness: with all four channels continuously valid, grants rotate 0,1,2,3,0,…, and each channel waits at most 3 accepted transfers.

## Configuration
- `ARB_FIXED_PRIO_EN`
  - Defined: fixed priority; the lowest-index valid channel always wins. `ptr` is removed (treated as constant 0).
  - Undefined (default): round-robin as described above.

## Structure
- Shared package `mux_pkg` holds:
  - `CHANNELS` = 4.
  - `SEL_W` = 2.
  - The `DATA_W` = 8 constant.
  - The `state_t` enum: EMPTY, FULL.
- One sub-module: `mux4_8bit`, instantiated as the datapath select. The grant index drives its `sel`.
- Grant search is a small function or always block inside this module; no separate arbiter module.

## Test plan
- **Single channel, after reset.** Reset, then `in_valid`=4'b0100, `in_data2`=8'hA5, `out_ready`=1 → `in_ready`=4'b0100, `sel`=2. Next cycle `out_valid`=1, `out_data`=A5, `out_chan`=2.
- **All channels, no backpressure.** All valid with data 10/11/12/13, `out_ready`=1 → `out_chan` sequence 0,1,2,3,0 on consecutive cycles, `out_valid` never drops.
- **Backpressure.** Register FULL with 8'h11, `out_ready`=0 for 3 cycles → `out_data` stays 11, `in_ready`=0, `ptr` unchanged. `out_ready`=1 → 11 is consumed and the next byte loads on the same edge.
- **Sparse requests.** `ptr`=3 and only channels 1 and 2 valid → channel 1 granted, then channel 2.
- **Reset while FULL.** Reset asserted while FULL → next cycle `out_valid`=0, `out_data`=0, `sel`=0; a pending channel 3 request is accepted only after reset deasserts.
- **Fixed priority.** With `ARB_FIXED_PRIO_EN` defined and channels 0 and 3 continuously valid → channel 0 is granted every cycle and channel 3 is never granted.
